// File: rtl/bin2bcd_converter.sv
// bin2bcd_converter: sequential binary-to-BCD converter (shift-and-add-3,
// one input bit per clock). Takes the multiplier product and produces a
// packed BCD word, a sign flag and a significant-digit count for the
// display window. Handshake is start/busy/done.
//
// Optional build macro: BCD_SIGNED_EN
//   defined   -> bin_in is two's complement; magnitude is converted and the
//                sign is reported on 'sign'.
//   undefined -> bin_in is unsigned; 'sign' is tied low and no negation
//                logic exists.
module bin2bcd_converter #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  flg,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  sign,
  output logic [2:0]            ndigits,
  output logic                  busy,
  output logic                  done
);

  localparam int BW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SHIFT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    scratch_q, scratch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic [2:0]       ndig_q, ndig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] magnitude;
  logic [BW-1:0]    adj;
  logic [2:0]       ndig_calc;

`ifdef BCD_SIGNED_EN
  logic sign_cap_q, sign_cap_d;
  logic sign_q, sign_d;

  // Two's complement negation in WIDTH bits; the most negative value maps
  // onto itself, which read unsigned is exactly its magnitude.
  assign magnitude = bin_in[WIDTH-1] ? (~bin_in + WIDTH'(1)) : bin_in;

  // Capture the sign at start, publish it together with the BCD result.
  always_comb begin
    sign_cap_d = sign_cap_q;
    sign_d     = sign_q;
    if (state_q == S_IDLE && start) begin
      sign_cap_d = bin_in[WIDTH-1];
    end
    if (state_q == S_FINISH) begin
      sign_d = sign_cap_q;
    end
  end

  // Sign registers, cleared by reset.
  always_ff @(posedge clk or posedge flg) begin
    if (flg) begin
      sign_cap_q <= 1'b0;
      sign_q     <= 1'b0;
    end else begin
      sign_cap_q <= sign_cap_d;
      sign_q     <= sign_d;
    end
  end

  assign sign = sign_q;
`else
  assign magnitude = bin_in;
  assign sign      = 1'b0;
`endif

  // Per-digit add-3 correction; a corrected digit is at most 12, so the
  // following shift never overflows a nibble and no inter-digit carry exists.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5)
                              ? scratch_q[gi*4 +: 4] + 4'd3
                              : scratch_q[gi*4 +: 4];
    end
  endgenerate

  // Significant-digit count: position of the highest nonzero digit plus one,
  // with a floor of 1 so that zero still shows one digit.
  always_comb begin
    ndig_calc = 3'd1;
    for (int i = 1; i < DIGITS; i++) begin
      if (scratch_q[i*4 +: 4] != 4'd0) begin
        ndig_calc = 3'(i + 1);
      end
    end
  end

  // Next-state logic for the IDLE -> SHIFT x WIDTH -> FINISH sequence.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    bcd_d     = bcd_q;
    ndig_d    = ndig_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d   = magnitude;
          scratch_d = '0;
          cnt_d     = '0;
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {scratch_d, shreg_d} = {adj[BW-2:0], shreg_q, 1'b0};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        bcd_d   = scratch_q;
        ndig_d  = ndig_calc;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge flg) begin
    if (flg) begin
      state_q   <= S_IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      ndig_q    <= 3'd1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      bcd_q     <= bcd_d;
      ndig_q    <= ndig_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bcd_out = bcd_q;
  assign ndigits = ndig_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bin2bcd_converter.sv
// Directed testbench for bin2bcd_converter (WIDTH=16, DIGITS=5).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bin2bcd_converter;

  logic        clk;
  logic        flg;
  logic        start;
  logic [15:0] bin_in;
  logic [19:0] bcd_out;
  logic        sign;
  logic [2:0]  ndigits;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  bin2bcd_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk     (clk),
    .flg     (flg),
    .start   (start),
    .bin_in  (bin_in),
    .bcd_out (bcd_out),
    .sign    (sign),
    .ndigits (ndigits),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one cycle; returns at the first busy cycle.
  task automatic launch(input logic [15:0] v);
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Wait (bounded) for done; reports cycles waited and busy cycles seen.
  task automatic wait_done(output int cyc, output int bcyc);
    cyc  = 0;
    bcyc = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1) bcyc++;
    end
  endtask

  task automatic test_reset;
    flg = 1'b1; start = 1'b0; bin_in = 16'h0;
    repeat (2) @(negedge clk);
    n_checks++; if (bcd_out !== 20'h0) begin n_fail++; $display("FAIL reset_bcd got=%h exp=%h", bcd_out, 20'h0); end
    n_checks++; if (sign !== 1'b0) begin n_fail++; $display("FAIL reset_sign got=%b exp=0", sign); end
    n_checks++; if (ndigits !== 3'd1) begin n_fail++; $display("FAIL reset_ndigits got=%0d exp=1", ndigits); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got=%b%b exp=00", busy, done); end
    flg = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy got=%b exp=0", busy); end
    $display("txn reset: bcd=%h ndigits=%0d busy=%b", bcd_out, ndigits, busy);
  endtask

  task automatic test_zero;
    int cyc, bcyc;
    launch(16'h0000);
    wait_done(cyc, bcyc);
    n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL zero_latency got=%0d exp=17", cyc); end
    n_checks++; if (bcyc !== 17) begin n_fail++; $display("FAIL zero_busy_cycles got=%0d exp=17", bcyc); end
    n_checks++; if (bcd_out !== 20'h00000) begin n_fail++; $display("FAIL zero_bcd got=%h exp=00000", bcd_out); end
    n_checks++; if (ndigits !== 3'd1) begin n_fail++; $display("FAIL zero_ndigits got=%0d exp=1", ndigits); end
    n_checks++; if (sign !== 1'b0) begin n_fail++; $display("FAIL zero_sign got=%b exp=0", sign); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse got=%b exp=0", done); end
    $display("txn 0x0000: bcd=%h ndigits=%0d sign=%b latency=%0d", bcd_out, ndigits, sign, cyc);
  endtask

  task automatic test_ignore_start;
    int cyc, bcyc, extra;
    launch(16'h3039);
    @(negedge clk);
    bin_in = 16'h0001;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy got=%b exp=1", busy); end
    wait_done(cyc, bcyc);
    n_checks++; if (cyc !== 15) begin n_fail++; $display("FAIL ignore_latency got=%0d exp=15", cyc); end
    n_checks++; if (bcd_out !== 20'h12345) begin n_fail++; $display("FAIL ignore_bcd got=%h exp=12345", bcd_out); end
    n_checks++; if (ndigits !== 3'd5) begin n_fail++; $display("FAIL ignore_ndigits got=%0d exp=5", ndigits); end
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ignore_no_requeue got=%0d exp=0", extra); end
    n_checks++; if (bcd_out !== 20'h12345) begin n_fail++; $display("FAIL ignore_hold got=%h exp=12345", bcd_out); end
    $display("txn 0x3039: bcd=%h ndigits=%0d (mid-busy start ignored)", bcd_out, ndigits);
  endtask

  task automatic test_full_scale;
    int cyc, bcyc;
    launch(16'hFFFF);
    wait_done(cyc, bcyc);
`ifdef BCD_SIGNED_EN
    n_checks++; if (bcd_out !== 20'h00001) begin n_fail++; $display("FAIL ffff_bcd got=%h exp=00001", bcd_out); end
    n_checks++; if (sign !== 1'b1) begin n_fail++; $display("FAIL ffff_sign got=%b exp=1", sign); end
    n_checks++; if (ndigits !== 3'd1) begin n_fail++; $display("FAIL ffff_ndigits got=%0d exp=1", ndigits); end
`else
    n_checks++; if (bcd_out !== 20'h65535) begin n_fail++; $display("FAIL ffff_bcd got=%h exp=65535", bcd_out); end
    n_checks++; if (sign !== 1'b0) begin n_fail++; $display("FAIL ffff_sign got=%b exp=0", sign); end
    n_checks++; if (ndigits !== 3'd5) begin n_fail++; $display("FAIL ffff_ndigits got=%0d exp=5", ndigits); end
`endif
    $display("txn 0xFFFF: bcd=%h ndigits=%0d sign=%b", bcd_out, ndigits, sign);
  endtask

  task automatic test_trailing_zeros;
    int cyc, bcyc;
    launch(16'h03E8);
    wait_done(cyc, bcyc);
    n_checks++; if (bcd_out !== 20'h01000) begin n_fail++; $display("FAIL k1000_bcd got=%h exp=01000", bcd_out); end
    n_checks++; if (ndigits !== 3'd4) begin n_fail++; $display("FAIL k1000_ndigits got=%0d exp=4", ndigits); end
    $display("txn 0x03E8: bcd=%h ndigits=%0d", bcd_out, ndigits);
  endtask

`ifdef BCD_SIGNED_EN
  task automatic test_signed;
    int cyc, bcyc;
    launch(16'h8000);
    wait_done(cyc, bcyc);
    n_checks++; if (bcd_out !== 20'h32768 || sign !== 1'b1) begin n_fail++; $display("FAIL most_neg got=%h/%b exp=32768/1", bcd_out, sign); end
    n_checks++; if (ndigits !== 3'd5) begin n_fail++; $display("FAIL most_neg_ndigits got=%0d exp=5", ndigits); end
    $display("txn 0x8000: bcd=%h ndigits=%0d sign=%b", bcd_out, ndigits, sign);
    launch(16'hFF85);
    wait_done(cyc, bcyc);
    n_checks++; if (bcd_out !== 20'h00123 || sign !== 1'b1) begin n_fail++; $display("FAIL neg123 got=%h/%b exp=00123/1", bcd_out, sign); end
    n_checks++; if (ndigits !== 3'd3) begin n_fail++; $display("FAIL neg123_ndigits got=%0d exp=3", ndigits); end
    $display("txn 0xFF85: bcd=%h ndigits=%0d sign=%b", bcd_out, ndigits, sign);
  endtask
`endif

  task automatic test_reset_mid;
    int cyc, bcyc, seen;
    launch(16'h0063);
    wait_done(cyc, bcyc);
    n_checks++; if (bcd_out !== 20'h00099 || ndigits !== 3'd2) begin n_fail++; $display("FAIL k99 got=%h/%0d exp=00099/2", bcd_out, ndigits); end
    $display("txn 0x0063: bcd=%h ndigits=%0d", bcd_out, ndigits);
    launch(16'h04D2);
    n_checks++; if (bcd_out !== 20'h00099) begin n_fail++; $display("FAIL hold_during_busy got=%h exp=00099", bcd_out); end
    repeat (7) @(negedge clk);
    flg = 1'b1;
    #1;
    n_checks++; if (bcd_out !== 20'h0 || busy !== 1'b0 || ndigits !== 3'd1) begin n_fail++; $display("FAIL abort got=%h/%b/%0d exp=00000/0/1", bcd_out, busy, ndigits); end
    @(negedge clk);
    flg = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    $display("txn 0x04D2 aborted: bcd=%h busy=%b ndigits=%0d", bcd_out, busy, ndigits);
  endtask

  task automatic test_back_to_back;
    int cyc, bcyc;
    launch(16'h0001);
    wait_done(cyc, bcyc);
    n_checks++; if (bcd_out !== 20'h00001) begin n_fail++; $display("FAIL b2b_first got=%h exp=00001", bcd_out); end
    bin_in = 16'h0007;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    n_checks++; if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_accept got=%b%b exp=10", busy, done); end
    wait_done(cyc, bcyc);
    n_checks++; if (cyc !== 17) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=17", cyc); end
    n_checks++; if (bcd_out !== 20'h00007 || ndigits !== 3'd1) begin n_fail++; $display("FAIL b2b_second got=%h/%0d exp=00007/1", bcd_out, ndigits); end
    $display("txn 0x0007 back-to-back: bcd=%h ndigits=%0d latency=%0d", bcd_out, ndigits, cyc);
  endtask

  initial begin
    flg = 1'b1; start = 1'b0; bin_in = 16'h0;
    test_reset;
    test_zero;
    test_ignore_start;
    test_full_scale;
    test_trailing_zeros;
`ifdef BCD_SIGNED_EN
    test_signed;
`endif
    test_reset_mid;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_converter.md
Name: bin2bcd_converter

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits between the signed multiplier product register and the display window/shifter block.
- Produces the packed 5-digit BCD word (20 bits) plus sign that the display window consumes.
- Handshake: start/busy/done. The result is held stable until the next conversion completes.

Parameters:
- WIDTH, 16, binary input width. Must be ≥ 2.
- DIGITS, 5, number of BCD digits produced. Requires 10^DIGITS > 2^WIDTH. Output width is 4*DIGITS.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- flg  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion of bin_in. Sampled only in IDLE.
- bin_in  input  WIDTH  value to convert. Captured on the edge where start is accepted.
- bcd_out  output  4*DIGITS  packed BCD. Digit 0 (units) is in [3:0]; the most significant digit is in the top nibble.
- sign  output  1  1 = bin_in was negative (macro-dependent, see Optional Feature).
- ndigits  output  3  count of significant digits, 1..DIGITS. A zero result gives 1.
- busy  output  1  high while a conversion is in progress.
- done  output  1  single-cycle pulse when bcd_out/sign/ndigits update.

Behaviour:
- Reset (flg=1, asynchronous):
  - state=IDLE.
  - bcd_out=0, sign=0, ndigits=1, busy=0, done=0.
  - Internal shift register and bit counter cleared.
- FSM states: IDLE, SHIFT, FINISH.
- IDLE:
  - done=0.
  - If start=1 at edge E0:
    - Capture the magnitude into a WIDTH-bit shift register.
    - Clear the BCD scratch register.
    - counter=0, busy<=1, go to SHIFT.
  - Otherwise remain in IDLE.
- SHIFT, one iteration per edge:
  - Every scratch digit ≥5 gets +3; digits ≤4 are unchanged.
  - Then shift {scratch, shreg} left by 1.
  - counter increments.
  - After WIDTH iterations (edge E0+WIDTH), go to FINISH.
- FINISH, one edge:
  - bcd_out<=scratch, sign<=captured sign.
  - ndigits<=index of the highest nonzero digit +1, or 1 if all digits are zero.
  - done<=1 for exactly one cycle, busy<=0, return to IDLE.
- Latency, default WIDTH=16:
  - start sampled at E0; done high in the cycle following E0+17.
  - busy is high from after E0 until after E0+17 (17 cycles).
- Back-to-back operation: start may be asserted in the same cycle done is high. The FSM is already in IDLE, so it is accepted; no idle gap is required.
- start while busy: ignored. It is not queued, and bin_in changes while busy have no effect.
- Outputs bcd_out/sign/ndigits hold their previous value during a conversion and change only on the FINISH edge.
- Reset mid-conversion: abort immediately; all outputs return to reset values; no done pulse.
- Add-3 correction is per nibble, 4-bit arithmetic. A digit never exceeds 9 after the shift, so no carry between digits is needed.

Optional Feature:
- Macro: BCD_SIGNED_EN.
- Defined:
  - bin_in is two's complement.
  - Captured magnitude = bin_in[WIDTH-1] ? -bin_in : bin_in, evaluated in WIDTH bits. The most-negative value (0x8000) yields magnitude 32768 as an unsigned value.
  - sign = bin_in[WIDTH-1] at capture.
- Not defined:
  - bin_in is unsigned; magnitude = bin_in.
  - sign output is tied to 0. No negation logic is synthesised.

Test Plan:
- bin_in=0x0000, start pulse -> after 17 busy cycles: done=1 for one cycle, bcd_out=0x00000, sign=0, ndigits=1.
- bin_in=0x3039 (12345) -> bcd_out=0x12345, ndigits=5, sign=0. A start pulse during busy with bin_in=0x0001 is ignored (result unchanged, no extra done).
- Without BCD_SIGNED_EN: bin_in=0xFFFF -> bcd_out=0x65535, sign=0. With BCD_SIGNED_EN: 0xFFFF -> bcd_out=0x00001, sign=1, ndigits=1.
- With BCD_SIGNED_EN: bin_in=0x8000 -> bcd_out=0x32768, sign=1. bin_in=0xFF85 (-123) -> bcd_out=0x00123, sign=1, ndigits=3.
- Convert 0x0063 (99) to completion (bcd_out=0x00099). Then start 0x04D2, assert flg at its 8th busy cycle -> immediately bcd_out=0, busy=0, ndigits=1; no done pulse.
- Back-to-back: start asserted in the done cycle with bin_in=0x0007 -> accepted, busy next cycle, second done after 17 cycles with bcd_out=0x00007.
